// File: rtl/hdlc_rx_checker.sv
// Multi-channel HDLC Rx status checker: flag-detect latency, abort signalling and
// end-of-frame status consistency, with sticky per-check flags and a saturating error count.
module hdlc_rx_checker #(
    parameter int NUM_CH   = 1,
    parameter int FLAG_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Chk_En,
    input  logic                  Err_Clr,
    input  logic [NUM_CH-1:0]     Rx,
    input  logic [NUM_CH-1:0]     Rx_FlagDetect,
    input  logic [NUM_CH-1:0]     Rx_ValidFrame,
    input  logic [NUM_CH-1:0]     Rx_AbortDetect,
    input  logic [NUM_CH-1:0]     Rx_AbortSignal,
    input  logic [NUM_CH-1:0]     Rx_EoF,
    input  logic [NUM_CH-1:0]     Rx_Overflow,
    input  logic [NUM_CH-1:0]     Rx_FrameError,
    input  logic [NUM_CH-1:0]     Rx_Ready,
    output logic [3*NUM_CH-1:0]   Err_Sticky,
    output logic [CNT_W-1:0]      Err_Count,
    output logic                  Err_Valid
);

    // Wide enough to add up to 48 simultaneous events without overflowing before saturation.
    localparam int SUM_W = CNT_W + 7;

    logic [NUM_CH-1:0][7:0]          r_hist;
    logic [NUM_CH-1:0][FLAG_LAT-1:0] r_fpipe;
    logic [NUM_CH-1:0]               r_ab_pend;
    logic [NUM_CH-1:0]               r_st_fail;
    logic [NUM_CH-1:0]               r_st_rdy;
    logic [NUM_CH-1:0]               r_eof_prev;
    logic [3*NUM_CH-1:0]             r_sticky;
    logic [CNT_W-1:0]                r_count;
    logic                            r_valid;

    logic [NUM_CH-1:0][FLAG_LAT:0]   w_fnext;
    logic [NUM_CH-1:0]               w_ab_trig;
    logic [NUM_CH-1:0]               w_eof_rise;
    logic [NUM_CH-1:0]               w_st_fail_now;
    logic [3*NUM_CH-1:0]             w_ev;
    logic [SUM_W-1:0]                w_pop;
    logic [SUM_W-1:0]                w_sum;
    logic [CNT_W-1:0]                w_base;
    logic [CNT_W-1:0]                w_count_nxt;

    always_comb begin
        w_fnext       = '0;
        w_ab_trig     = '0;
        w_eof_rise    = '0;
        w_st_fail_now = '0;
        w_ev          = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // Current Rx completes the 8-bit window, so a match is seen on the final flag bit.
            w_fnext[i]    = {r_fpipe[i], Chk_En & ({r_hist[i][6:0], Rx[i]} == 8'b0111_1110)};
            w_ab_trig[i]  = Chk_En & Rx_AbortDetect[i] & Rx_ValidFrame[i];
            w_eof_rise[i] = Chk_En & Rx_EoF[i] & ~r_eof_prev[i];
            if (Rx_AbortSignal[i])
                w_st_fail_now[i] = Rx_Overflow[i] | Rx_FrameError[i];
            else if (Rx_Overflow[i])
                w_st_fail_now[i] = Rx_FrameError[i] | ~Rx_Ready[i];
            else if (Rx_FrameError[i])
                w_st_fail_now[i] = Rx_Ready[i];
            else
                w_st_fail_now[i] = ~Rx_Ready[i];
            w_ev[3*i+0] = r_fpipe[i][FLAG_LAT-1] & ~Rx_FlagDetect[i];
            w_ev[3*i+1] = r_ab_pend[i] & ~Rx_AbortSignal[i];
            // Abort-branch Ready term folds into the same single status event.
            w_ev[3*i+2] = r_st_fail[i] | (r_st_rdy[i] & Rx_Ready[i]);
        end
    end

    always_comb begin
        w_pop = '0;
        for (int j = 0; j < 3*NUM_CH; j++)
            w_pop = w_pop + SUM_W'(w_ev[j]);
        // Clear takes effect first so errors in the clearing cycle are kept.
        w_base = Err_Clr ? '0 : r_count;
        w_sum  = SUM_W'(w_base) + w_pop;
        if (w_sum > SUM_W'({CNT_W{1'b1}}))
            w_count_nxt = '1;
        else
            w_count_nxt = w_sum[CNT_W-1:0];
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_hist     <= '0;
            r_fpipe    <= '0;
            r_ab_pend  <= '0;
            r_st_fail  <= '0;
            r_st_rdy   <= '0;
            r_eof_prev <= '1;
            r_sticky   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_hist[i]  <= {r_hist[i][6:0], Rx[i]};
                r_fpipe[i] <= w_fnext[i][FLAG_LAT-1:0];
            end
            r_ab_pend  <= w_ab_trig;
            r_st_fail  <= w_eof_rise & w_st_fail_now;
            r_st_rdy   <= w_eof_rise & Rx_AbortSignal;
            r_eof_prev <= Rx_EoF;
            r_sticky   <= (Err_Clr ? '0 : r_sticky) | w_ev;
            r_count    <= w_count_nxt;
            r_valid    <= |w_ev;
        end
    end

    assign Err_Sticky = r_sticky;
    assign Err_Count  = r_count;
    assign Err_Valid  = r_valid;

endmodule

// File: tb/tb_hdlc_rx_checker.sv
// Directed bench for hdlc_rx_checker: a single-channel instance for the per-check cases and a
// four-channel, 4-bit-counter instance for saturation and clear-with-new-errors.
module tb_hdlc_rx_checker;

    logic Clk;
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Single-channel instance
    logic        c1_rst, c1_en, c1_clr;
    logic        c1_rx, c1_fd, c1_vf, c1_ad, c1_as, c1_eof, c1_of, c1_fe, c1_rdy;
    logic [2:0]  c1_stk;
    logic [15:0] c1_cnt;
    logic        c1_val;

    // Four-channel instance
    logic        c4_rst, c4_en, c4_clr;
    logic [3:0]  c4_rx, c4_fd, c4_vf, c4_ad, c4_as, c4_eof, c4_of, c4_fe, c4_rdy;
    logic [11:0] c4_stk;
    logic [3:0]  c4_cnt;
    logic        c4_val;

    hdlc_rx_checker #(.NUM_CH(1), .FLAG_LAT(2), .CNT_W(16)) dut1 (
        .Clk(Clk), .Rst(c1_rst), .Chk_En(c1_en), .Err_Clr(c1_clr),
        .Rx(c1_rx), .Rx_FlagDetect(c1_fd), .Rx_ValidFrame(c1_vf),
        .Rx_AbortDetect(c1_ad), .Rx_AbortSignal(c1_as), .Rx_EoF(c1_eof),
        .Rx_Overflow(c1_of), .Rx_FrameError(c1_fe), .Rx_Ready(c1_rdy),
        .Err_Sticky(c1_stk), .Err_Count(c1_cnt), .Err_Valid(c1_val)
    );

    hdlc_rx_checker #(.NUM_CH(4), .FLAG_LAT(2), .CNT_W(4)) dut4 (
        .Clk(Clk), .Rst(c4_rst), .Chk_En(c4_en), .Err_Clr(c4_clr),
        .Rx(c4_rx), .Rx_FlagDetect(c4_fd), .Rx_ValidFrame(c4_vf),
        .Rx_AbortDetect(c4_ad), .Rx_AbortSignal(c4_as), .Rx_EoF(c4_eof),
        .Rx_Overflow(c4_of), .Rx_FrameError(c4_fe), .Rx_Ready(c4_rdy),
        .Err_Sticky(c4_stk), .Err_Count(c4_cnt), .Err_Valid(c4_val)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int v1_pulses = 0;
    int v1_mark;

    logic [31:0] exp_q[$];

    always @(negedge Clk) if (c1_val === 1'b1) v1_pulses++;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed=%0h but scoreboard queue empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, e);
            end
        end
    endtask

    // Flag 01111110 on channel 0 of dut1; FlagDetect pulsed fd_at cycles after the final 0.
    task automatic send_flag1(input logic en, input int fd_at, input bit rst_mid);
        logic [7:0] pat;
        pat   = 8'b0111_1110;
        c1_en = en;
        for (int b = 7; b >= 0; b--) begin
            c1_rx = pat[b];
            tick();
        end
        for (int k = 1; k <= 5; k++) begin
            c1_rx = 1'b0;
            c1_fd = (k == fd_at);
            if (rst_mid) c1_rst = (k == 1);
            tick();
        end
        c1_fd = 1'b0;
        c1_en = 1'b1;
        tick();
    endtask

    // Same flag on all four channels of dut4 with FlagDetect never raised.
    task automatic send_flag4();
        logic [7:0] pat;
        pat = 8'b0111_1110;
        for (int b = 7; b >= 0; b--) begin
            c4_rx = {4{pat[b]}};
            tick();
        end
        c4_rx = 4'b0;
        repeat (5) tick();
    endtask

    task automatic eof_pulse1(input logic as, input logic of, input logic fe,
                              input logic rdy_t, input logic rdy_t1);
        c1_eof = 1'b1; c1_as = as; c1_of = of; c1_fe = fe; c1_rdy = rdy_t;
        tick();
        c1_eof = 1'b0; c1_as = 1'b0; c1_of = 1'b0; c1_fe = 1'b0; c1_rdy = rdy_t1;
        tick();
        c1_rdy = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        c1_rst = 1'b1; c1_en = 1'b1; c1_clr = 1'b0;
        c1_rx = 0; c1_fd = 0; c1_vf = 0; c1_ad = 0; c1_as = 0;
        c1_eof = 1'b1; c1_of = 0; c1_fe = 0; c1_rdy = 0;
        c4_rst = 1'b1; c4_en = 1'b1; c4_clr = 1'b0;
        c4_rx = '0; c4_fd = '0; c4_vf = '0; c4_ad = '0; c4_as = '0;
        c4_eof = '0; c4_of = '0; c4_fe = '0; c4_rdy = '0;
        repeat (2) tick();
        c1_rst = 1'b0; c4_rst = 1'b0;
        tick();

        push_exp(0); sb_check("c1_count_reset", c1_cnt);
        push_exp(0); sb_check("c1_sticky_reset", c1_stk);
        push_exp(0); sb_check("c1_valid_reset", c1_val);
        push_exp(0); sb_check("c4_count_reset", c4_cnt);
        push_exp(0); sb_check("c4_sticky_reset", c4_stk);
        push_exp(0); sb_check("c4_valid_reset", c4_val);

        // EoF held high through reset with Ready low must not trigger a status check.
        repeat (3) tick();
        push_exp(0); sb_check("eof_held_from_reset", c1_cnt);
        c1_eof = 1'b0;
        tick();

        send_flag1(1'b1, 2, 1'b0);
        push_exp(0); sb_check("flag_on_time_count", c1_cnt);
        push_exp(0); sb_check("flag_on_time_sticky", c1_stk);

        v1_mark = v1_pulses;
        send_flag1(1'b1, 3, 1'b0);
        push_exp(1);      sb_check("flag_late_count", c1_cnt);
        push_exp(3'b001); sb_check("flag_late_sticky", c1_stk);
        push_exp(1);      sb_check("flag_late_valid_pulses", v1_pulses - v1_mark);

        c1_ad = 1'b1; c1_vf = 1'b1;
        tick();
        c1_ad = 1'b0; c1_vf = 1'b0; c1_as = 1'b0;
        repeat (3) tick();
        push_exp(2);      sb_check("abort_missing_count", c1_cnt);
        push_exp(3'b011); sb_check("abort_missing_sticky", c1_stk);

        c1_ad = 1'b1; c1_vf = 1'b0;
        tick();
        c1_ad = 1'b0;
        repeat (3) tick();
        push_exp(2); sb_check("abort_no_validframe_count", c1_cnt);

        eof_pulse1(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        push_exp(3);      sb_check("eof_abort_ready_count", c1_cnt);
        push_exp(3'b111); sb_check("eof_abort_ready_sticky", c1_stk);

        eof_pulse1(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        push_exp(3); sb_check("eof_clean_count", c1_cnt);

        eof_pulse1(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push_exp(4); sb_check("eof_overflow_not_ready_count", c1_cnt);

        eof_pulse1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp(4); sb_check("eof_frameerror_clean_count", c1_cnt);

        send_flag1(1'b0, 0, 1'b0);
        push_exp(4); sb_check("flag_chk_en_low_count", c1_cnt);

        send_flag1(1'b1, 0, 1'b1);
        push_exp(0); sb_check("flag_reset_mid_count", c1_cnt);
        push_exp(0); sb_check("flag_reset_mid_sticky", c1_stk);

        send_flag4();
        push_exp(4);  sb_check("sat_frame1_count", c4_cnt);
        send_flag4();
        push_exp(8);  sb_check("sat_frame2_count", c4_cnt);
        send_flag4();
        push_exp(12); sb_check("sat_frame3_count", c4_cnt);
        send_flag4();
        push_exp(15);      sb_check("sat_frame4_count", c4_cnt);
        push_exp(12'h249); sb_check("sat_sticky", c4_stk);

        // Two abort errors land in the same cycle as the clear.
        c4_ad = 4'b0110; c4_vf = 4'b0110;
        tick();
        c4_ad = 4'b0; c4_vf = 4'b0; c4_as = 4'b0; c4_clr = 1'b1;
        tick();
        c4_clr = 1'b0;
        repeat (2) tick();
        push_exp(2);       sb_check("clear_with_errors_count", c4_cnt);
        push_exp(12'h090); sb_check("clear_with_errors_sticky", c4_stk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
